btpipe_in_buffer: RTL and testbench

BTPIPE_IN_BUFFER -- requirements
Module: btpipe_in_buffer

---
 rtl/btpipe_pkg.sv | 17 +
 rtl/btpipe_in_buffer_if.sv | 23 ++
 rtl/sdp_ram.sv | 20 ++
 rtl/btpipe_in_buffer.sv | 102 ++++++++++
 tb/tb_btpipe_in_buffer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/btpipe_pkg.sv
// Shared defaults and output-register state encoding for the block-throttled pipe-in buffer.
package btpipe_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_DEPTH_LOG2  = 10;
    localparam int DEF_BLOCK_WORDS = 256;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/btpipe_in_buffer_if.sv
// Host pipe-in write side and downstream pop side of the buffer.
interface btpipe_in_buffer_if
    import btpipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              in_write;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_read;

    modport master (
        output in_write, in_data, out_read,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_write, in_data, out_read,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/btpipe_in_buffer.sv
// FWFT buffer between a block-throttled pipe-in endpoint and a checker; the RAM read
// register doubles as the output register, so out_valid tracks its EMPTY/HOLD state.
module btpipe_in_buffer
    import btpipe_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    btpipe_in_buffer_if.slave    bus,
    output logic [DEPTH_LOG2:0]  level,
    output logic [15:0]          overflow_count,
    output logic [15:0]          block_count
);
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] DEPTH     = LVL_W'(1) << DEPTH_LOG2;
    localparam logic [LVL_W-1:0] BLOCK     = LVL_W'(BLOCK_WORDS);
    localparam logic [LVL_W-1:0] BPOS_LAST = LVL_W'(BLOCK_WORDS - 1);

    out_state_e            state;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LVL_W-1:0]      bpos;
    logic                  ready_q;
    logic [DATA_W-1:0]     ram_q;

    logic                  wr_acc;
    logic                  drop;
    logic                  pop;
    logic                  load;
    logic [LVL_W-1:0]      ram_cnt;
    logic [LVL_W-1:0]      level_next;

    // ram_cnt excludes the word parked in the output register; it can never reach
    // DEPTH while that register holds, so wr_ptr and rd_ptr never collide on a live read.
    always_comb begin
        ram_cnt    = level - LVL_W'(state == OUT_HOLD);
        wr_acc     = !reset && bus.in_write && (level != DEPTH);
        drop       = !reset && bus.in_write && (level == DEPTH);
        pop        = !reset && bus.out_read && (state == OUT_HOLD);
        load       = !reset && (ram_cnt != '0) && ((state == OUT_EMPTY) || bus.out_read);
        level_next = level + LVL_W'(wr_acc) - LVL_W'(pop);
    end

    sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.in_data),
        .rd_en   (load),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= OUT_EMPTY;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            bpos           <= '0;
            ready_q        <= 1'b0;
            overflow_count <= '0;
            block_count    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);

            // A pop that refills from RAM stays in HOLD with no bubble.
            if (load) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                state  <= OUT_HOLD;
            end else if (pop) begin
                state  <= OUT_EMPTY;
            end

            level   <= level_next;
            ready_q <= (DEPTH - level_next) >= BLOCK;

            if (drop) overflow_count <= sat_inc16(overflow_count);

            // Host framing counts every strobe, dropped or not.
            if (bus.in_write) begin
                if (bpos == BPOS_LAST) begin
                    bpos        <= '0;
                    block_count <= block_count + 16'd1;
                end else begin
                    bpos <= bpos + LVL_W'(1);
                end
            end
        end
    end

    assign bus.out_valid = (state == OUT_HOLD);
    assign bus.out_data  = ram_q;
    assign bus.in_ready  = ready_q;

endmodule

// File: tb/tb_btpipe_in_buffer.sv
// Scoreboarded bench: the driver models the buffer as a queue of availability times,
// a separate monitor pops expected words whenever the DUT pops.
module tb_btpipe_in_buffer;
    localparam int DATA_W     = 16;
    localparam int DEPTH_LOG2 = 10;
    localparam int BLOCK      = 256;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                reset;
    logic [DEPTH_LOG2:0] level;
    logic [15:0]         overflow_count;
    logic [15:0]         block_count;

    btpipe_in_buffer_if #(.DATA_W(DATA_W)) bus ();

    btpipe_in_buffer #(
        .DATA_W      (DATA_W),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .BLOCK_WORDS (BLOCK)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .level          (level),
        .overflow_count (overflow_count),
        .block_count    (block_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned t = 0;

    // Model: one entry per buffered word holding the first cycle it may be seen.
    int unsigned av_q[$];
    logic [15:0] exp_q[$];
    int unsigned m_ovf = 0;
    int unsigned m_strobes = 0;
    bit          m_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, t);
        end
    endtask

    function automatic bit m_valid();
        return av_q.size() > 0 && av_q[0] <= t;
    endfunction

    task automatic cyc(input bit w, input logic [15:0] d, input bit r, input bit rst);
        bit          v;
        bit          acc;
        int unsigned h;
        v = m_valid();
        chk("out_valid", 32'(bus.out_valid), 32'(v));
        chk("level", 32'(level), 32'(av_q.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
        chk("overflow_count", 32'(overflow_count), (m_ovf > 65535) ? 32'd65535 : 32'(m_ovf));
        chk("block_count", 32'(block_count), 32'((m_strobes / BLOCK) % 65536));
        reset        = rst;
        bus.in_write = w;
        bus.in_data  = d;
        bus.out_read = r;
        if (rst) begin
            av_q.delete();
            exp_q.delete();
            m_ovf     = 0;
            m_strobes = 0;
            m_ready   = 1'b0;
        end else begin
            acc = w && (av_q.size() < DEPTH);
            if (w) m_strobes++;
            if (w && !acc) m_ovf++;
            if (r && v) begin
                void'(av_q.pop_front());
                // New head is visible no earlier than the cycle after the pop.
                if (av_q.size() > 0 && av_q[0] < t + 1) begin
                    h = av_q.pop_front();
                    h = t + 1;
                    av_q.push_front(h);
                end
            end
            if (acc) begin
                av_q.push_back(t + 2);
                exp_q.push_back(d);
            end
            m_ready = (DEPTH - av_q.size()) >= BLOCK;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && av_q.size() > 0; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    // Monitor: every DUT pop must match the oldest accepted word.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid === 1'b1 && bus.out_read === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=%0h expected=none cycle=%0d", bus.out_data, t);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=running expected=finished cycle=%0d", t);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [15:0] k;
        reset        = 1'b1;
        bus.in_write = 1'b0;
        bus.in_data  = '0;
        bus.out_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, 16'h1234, 1'b1, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // Empty fill
        cyc(1'b1, 16'h0001, 1'b0, 1'b0);
        cyc(1'b1, 16'h0002, 1'b0, 1'b0);
        cyc(1'b1, 16'h0003, 1'b0, 1'b0);
        chk("fill_head", 32'(bus.out_data), 32'h0001);
        chk("fill_level", 32'(level), 32'd3);
        drain();

        // Throttle, then overflow
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        k = 16'd1;
        for (int i = 0; i < 769; i++) begin cyc(1'b1, k, 1'b0, 1'b0); k++; end
        chk("throttle_low", 32'(bus.in_ready), 32'd0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("throttle_back", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 256; i++) begin cyc(1'b1, k, 1'b0, 1'b0); k++; end
        cyc(1'b1, 16'hD001, 1'b0, 1'b0);
        cyc(1'b1, 16'hD002, 1'b0, 1'b0);
        cyc(1'b1, 16'hD003, 1'b1, 1'b0);
        chk("ovf_count", 32'(overflow_count), 32'd3);
        chk("ovf_level", 32'(level), 32'd1023);
        drain();

        // Streaming with continuous reads
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4096; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
        drain();
        chk("stream_blocks", 32'(block_count), 32'd16);

        // Reset mid-block
        for (int i = 0; i < 100; i++) cyc(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_blocks", 32'(block_count), 32'd0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("rst_first", 32'(bus.out_data), 32'h0000BEEF);
        drain();

        // Random traffic: balanced, then write-heavy to reach full
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 45,
                $urandom_range(0, 999) == 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) < 90, 16'($urandom), $urandom_range(0, 99) < 20,
                $urandom_range(0, 1999) == 0);
        drain();

        // Overflow saturation
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("ovf_sat", 32'(overflow_count), 32'h0000FFFF);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
